result_bcd_decoder: RTL
=======================

Name: result_bcd_decoder

Overview:
- Sequential back end for the 4-bit adder/subtractor datapath.
- Takes the 8-bit result S and its interpretation mode, then converts it to sign + BCD digits using a multi-cycle double-dabble (shift/add-3) FSM.
- Output feeds the board's seven-segment display driver.
- Handshake is start/busy/done, so the display side samples only stable, complete results.

Parameters:
- WIDTH, 8, binary input width.
- DIGITS, 3, BCD output digits. Constraint: 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request conversion. Sampled only in IDLE.
- is_signed  input  1  1: bin is two's complement (subtraction result). 0: bin is unsigned.
- bin  input  WIDTH  value to convert. Captured on the accepted start edge.
- busy  output  1  high from the edge after start is accepted until the edge on which done rises.
- done  output  1  one-cycle pulse; outputs are valid from this cycle on.
- neg  output  1  sign of the last converted value.
- bcd  output  4*DIGITS  packed digits, most significant digit at the top nibble.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, neg=0, bcd=0, iteration count=0.
- rst_n low mid-conversion: the in-flight conversion is abandoned and the reset values apply on the next edge. No done is produced.
- States and transitions:
  - IDLE: on start=1 at edge k, capture bin and is_signed, go to CONV.
    - Magnitude = (is_signed && bin[WIDTH-1]) ? -bin : bin, computed in WIDTH bits as unsigned.
    - Signed minimum 0x80 gives magnitude 128, neg=1.
    - Internal neg_next = is_signed & bin[WIDTH-1].
    - Scratch BCD register cleared; count=0.
  - CONV: each edge, apply add-3 to every BCD nibble >= 5, then shift {bcd_scratch, mag} left by 1 and increment count.
    - After exactly WIDTH iterations (edges k+1..k+WIDTH), go to DONE.
  - DONE: at edge k+WIDTH+1, load bcd from scratch and neg from neg_next.
    - done=1 and busy=0 for this one cycle, then return to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1. That is 9 cycles after accept for WIDTH=8.
- busy is high after edges k+1..k+WIDTH.
- start handling:
  - start while busy or in DONE is ignored; it is not queued.
  - start held high re-triggers in the first IDLE cycle after done, sampling the bin present then.
- bin and is_signed may change freely after the accept edge without affecting the result.
- bcd and neg hold their last values until the next done. They never show partial values.
- Unsigned mode: bin is 0..2^WIDTH-1 and neg is always 0.
- Zero in either mode: bcd=0, neg=0. There is no negative zero.

Decomposition:
- Shared package calc_pkg holds:
  - FSM state enum (IDLE, CONV, DONE).
  - ADD3_THRESH = 4'd5, ADD3_VAL = 4'd3.
  - Default WIDTH/DIGITS constants, so the display driver and this block agree.
- Natural sub-module: bcd_add3_digit. It is a combinational 4-bit corrector (in >= 5 ? in+3 : in), instantiated DIGITS times by generate.

Test Plan:
1. is_signed=0, bin=0x08 (5+3), pulse start -> done exactly 9 cycles after accept, bcd=0x008, neg=0. busy high for 8 cycles.
2. is_signed=1, bin=0xF9 (3-10) -> neg=1, bcd=0x007. Then is_signed=1, bin=0x80 -> neg=1, bcd=0x128.
3. is_signed=0, bin=0xFF -> bcd=0x255, neg=0. Then is_signed=1, bin=0x00 (15-15) -> bcd=0x000, neg=0.
4. Accept bin=0x1E, then pulse start with bin=0x63 at cycle 4 of CONV -> single done with bcd=0x030 and no second done. Holding start high afterwards -> new conversion begins in the first IDLE cycle after done.
5. Accept bin=0x1E, then drive rst_n low at cycle 5 for one edge -> busy=0, bcd=0, neg=0, no done pulse. Next start with bin=0x10 -> bcd=0x016 after 9 cycles.
6. Back-to-back: bin changed on the cycle after accept -> result reflects the captured value only. bcd is stable between done pulses.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator-datapath definitions: conversion FSM states, add-3 constants
// and the default result width/digit count agreed with the display driver.
package calc_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more so the next
// left shift carries correctly into the neighbouring digit. Purely combinational.
module bcd_add3_digit
  import calc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] nibble_adj
);

  assign nibble_adj = (nibble >= ADD3_THRESH) ? nibble + ADD3_VAL : nibble;

endmodule

// File: rtl/result_bcd_decoder.sv
// Converts the adder result to sign + BCD with a WIDTH-iteration double-dabble FSM.
// done pulses WIDTH+1 cycles after accept; start is ignored (not queued) unless IDLE.
module result_bcd_decoder
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mag_q;
  logic [WIDTH-1:0]      mag_in;
  logic [4*DIGITS-1:0]   scr_q;
  logic [4*DIGITS-1:0]   scr_adj;
  logic                  neg_next_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q, neg_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  accept, shifting, load;

  // Two's complement magnitude in WIDTH bits; the signed minimum maps to 2^(WIDTH-1).
  assign mag_in = (is_signed & bin[WIDTH-1]) ? (~bin + 1'b1) : bin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .nibble     (scr_q[4*g +: 4]),
      .nibble_adj (scr_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shifting = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        shifting = 1'b1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DONE: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_q      <= '0;
      scr_q      <= '0;
      neg_next_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      busy_q <= (state_q == CONV);
      done_q <= load;
      if (accept) begin
        mag_q      <= mag_in;
        neg_next_q <= is_signed & bin[WIDTH-1];
        scr_q      <= '0;
        cnt_q      <= '0;
      end else if (shifting) begin
        {scr_q, mag_q} <= {scr_adj, mag_q} << 1;
        cnt_q          <= cnt_q + 1'b1;
      end
      // Visible outputs only change here, so the display never sees partial digits.
      if (load) begin
        bcd_q <= scr_q;
        neg_q <= neg_next_q;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign neg  = neg_q;
  assign bcd  = bcd_q;

endmodule
